cpu64_l1_mem_responder: RTL
===========================

CPU64_L1_MEM_RESPONDER -- requirements
Module: cpu64_l1_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 64-bit backing words; it SHALL be a power of two.
REQ-002 SHALL have parameter RD_LAT, default 2, meaning the number of cycles from the read-grant cycle to the rvalid cycle; the legal range is 1..7.
REQ-003 clk_i  in  1  clock; all logic is rising-edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 req_i  in  1  request from the L1 memory-side port.
REQ-006 we_i  in  1  1 = write, 0 = read.
REQ-007 be_i  in  8  byte enables for writes.
REQ-008 addr_i  in  64  byte address; only bits [2:0]=0 are legal.
REQ-009 wdata_i  in  64  write data.
REQ-010 gnt_o  out  1  grant pulse.
REQ-011 rvalid_o  out  1  read data valid.
REQ-012 rdata_o  out  64  read data.
REQ-013 inv_req_i  in  1  one-cycle command to back-invalidate a line.
REQ-014 inv_addr_i  in  64  address of the line to invalidate.
REQ-015 inv_busy_o  out  1  back-invalidate in progress.
REQ-016 binv_req_o  out  1  back-invalidate request to L1.
REQ-017 binv_addr_o  out  64  line address, with [5:0] forced to 0.
REQ-018 binv_ack_i  in  1  back-invalidate acknowledge from L1.

Function
REQ-019 The word index SHALL be addr_i[3+log2(MEM_WORDS)-1:3]; higher address bits are ignored, so addresses wrap modulo the memory size.
REQ-020 The data FSM SHALL have states IDLE, BLANK and RD_WAIT; all outputs SHALL be registered.
REQ-021 IDLE with req_i=1 SHALL cause gnt_o=1 in the next cycle for exactly one cycle, and the FSM SHALL then enter BLANK (write) or RD_WAIT (read).
REQ-022 A write SHALL update the memory at the grant edge: byte k is written only where be_i[k]=1, and be_i=8'h00 leaves the word unchanged.
REQ-023 A write SHALL never produce rvalid_o.
REQ-024 BLANK SHALL last exactly one cycle, SHALL ignore req_i, and SHALL then return to IDLE. This absorbs the requester's registered req, which remains high for one cycle after grant, and prevents double issue.
REQ-025 A read SHALL capture the word and address at the grant edge.
REQ-026 For a read, rvalid_o=1 with rdata_o SHALL be asserted for exactly one cycle, exactly RD_LAT cycles after the gnt_o cycle.
REQ-027 rdata_o SHALL be 0 whenever rvalid_o=0.
REQ-028 req_i SHALL be ignored during RD_WAIT.
REQ-029 After the rvalid cycle, the FSM SHALL spend one BLANK cycle, then return to IDLE.
REQ-030 Back-to-back accesses SHALL be throughput-limited to one write per 2 cycles and one read per RD_LAT+2 cycles.
REQ-031 The invalidate FSM SHALL have states INV_IDLE and INV_WAIT and SHALL be independent of the data FSM; memory traffic, including L1 writebacks, SHALL continue during INV_WAIT.
REQ-032 In INV_IDLE, inv_req_i=1 SHALL latch the line address, set binv_req_o=1 and inv_busy_o=1 from the next cycle, and enter INV_WAIT.
REQ-033 In INV_WAIT, binv_req_o and binv_addr_o SHALL be held stable until binv_ack_i=1 is sampled.
REQ-034 On sampling binv_ack_i=1, binv_req_o and inv_busy_o SHALL fall in the next cycle and the FSM SHALL return to INV_IDLE.
REQ-035 binv_ack_i SHALL be ignored in INV_IDLE, which tolerates a duplicate ack from L1.
REQ-036 inv_req_i asserted in INV_WAIT SHALL be dropped.
REQ-037 inv_req_i arriving in the same cycle as the ack SHALL also be dropped; the issuer SHALL wait for inv_busy_o=0.

Reset
REQ-038 During reset, gnt_o, rvalid_o, rdata_o, binv_req_o, binv_addr_o and inv_busy_o SHALL all be 0, and both FSMs SHALL be in their idle states.
REQ-039 Memory contents SHALL NOT be reset.
REQ-040 Reset mid-read SHALL abort the read, with no rvalid_o after reset release.
REQ-041 Reset mid-invalidate SHALL drop binv_req_o immediately.
REQ-042 The first request sampled after reset release SHALL be granted normally.

Verification
REQ-043 Write 0x1122334455667788 to address 0x40 with be=FF, then read 0x40 -> gnt_o 1 cycle after req, rvalid_o exactly 2 cycles after gnt_o (RD_LAT=2), rdata_o=0x1122334455667788, no rvalid_o for the write.
REQ-044 Write 0xAAAA... to address 0x40 with be=0x0F, then read 0x40 -> rdata_o=0x11223344AAAAAAAA.
REQ-045 Hold req_i=1 continuously for 8 writes, modelling the L1 writeback -> gnt_o pulses on every other cycle, exactly 8 grants, 8 words written.
REQ-046 Write 0x5 to address 0x0, then read address MEM_WORDS*8 -> rdata_o=0x5 (wrap-around).
REQ-047 inv_req_i with address 0x1234 -> binv_addr_o=0x1200; binv_ack_i after 5 cycles -> binv_req_o falls 1 cycle later; a second ack is ignored; reads issued concurrently complete correctly.
REQ-048 Assert rst_ni=0 one cycle after a read grant -> no rvalid_o ever appears; after release, a new read completes with correct data.

Source files
------------

// File: rtl/cpu64_l1_mem_responder.sv
// Backing-store responder for the L1 memory-side port, with an independent
// back-invalidate handshake that tells the L1 to drop a line.
module cpu64_l1_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int RD_LAT    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  be_i,
  input  logic [63:0] addr_i,
  input  logic [63:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [63:0] rdata_o,
  input  logic        inv_req_i,
  input  logic [63:0] inv_addr_i,
  output logic        inv_busy_o,
  output logic        binv_req_o,
  output logic [63:0] binv_addr_o,
  input  logic        binv_ack_i
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BLANK   = 2'd1,
    RD_WAIT = 2'd2
  } data_state_e;

  typedef enum logic {
    INV_IDLE = 1'b0,
    INV_WAIT = 1'b1
  } inv_state_e;

  data_state_e   r_state;
  inv_state_e    r_inv_state;
  logic [63:0]   r_mem [MEM_WORDS];
  logic [63:0]   r_rd_word;
  logic [2:0]    r_cnt;
  logic          r_gnt;
  logic          r_rvalid;
  logic [63:0]   r_rdata;
  logic          r_binv_req;
  logic          r_inv_busy;
  logic [63:0]   r_binv_addr;

  logic [AW-1:0] w_idx;
  logic          w_wr_en;
  logic          w_unused_addr;

  assign w_idx   = addr_i[3+AW-1:3];
  // Gate with rst_ni so a request seen while reset is held cannot touch memory.
  assign w_wr_en = rst_ni && (r_state == IDLE) && req_i && we_i;
  assign w_unused_addr = ^{addr_i[63:3+AW], addr_i[2:0], inv_addr_i[5:0]};

  // Byte-masked memory write at the grant edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      for (int k = 0; k < 8; k++) begin
        if (be_i[k]) begin
          r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Data FSM: grant, read latency countdown, and the one-cycle BLANK that
  // swallows the requester's late-dropping req.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_rd_word <= 64'd0;
      r_gnt     <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= 64'd0;
    end else begin
      r_gnt    <= 1'b0;
      r_rvalid <= 1'b0;
      r_rdata  <= 64'd0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_gnt <= 1'b1;
            if (we_i) begin
              r_state <= BLANK;
            end else begin
              r_rd_word <= r_mem[w_idx];
              r_cnt     <= 3'(RD_LAT - 1);
              r_state   <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (r_cnt == 3'd0) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_rd_word;
            r_state  <= BLANK;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        BLANK:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Invalidate FSM: runs alongside data traffic; new commands are dropped while busy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inv_state <= INV_IDLE;
      r_binv_req  <= 1'b0;
      r_inv_busy  <= 1'b0;
      r_binv_addr <= 64'd0;
    end else begin
      case (r_inv_state)
        INV_IDLE: begin
          if (inv_req_i) begin
            r_binv_addr <= {inv_addr_i[63:6], 6'd0};
            r_binv_req  <= 1'b1;
            r_inv_busy  <= 1'b1;
            r_inv_state <= INV_WAIT;
          end
        end
        INV_WAIT: begin
          if (binv_ack_i) begin
            r_binv_req  <= 1'b0;
            r_inv_busy  <= 1'b0;
            r_inv_state <= INV_IDLE;
          end
        end
        default: begin
          r_binv_req  <= 1'b0;
          r_inv_busy  <= 1'b0;
          r_inv_state <= INV_IDLE;
        end
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = r_rdata;
  assign binv_req_o  = r_binv_req;
  assign inv_busy_o  = r_inv_busy;
  assign binv_addr_o = r_binv_addr;

endmodule
